fetch_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit five-stage core, directly upstream of the decode stage.
- Owns the PC and boots from the reset vector stored in instruction memory.
- Fetches one- and two-word (immediate-carrying) instructions from a combinational-read instruction memory and drives the IF/ID pipeline register that decode consumes.
- Honours stall from the hazard unit and redirect/flush from branch resolution.

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: boots the PC from imem, fetches one/two-word instructions into IF/ID
module fetch_stage #(
  parameter int PC_W = 16,
  parameter int RESET_ADDR = 0,
  parameter int IMM_BIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     if_instr,
  output logic [15:0]     if_imm,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_next_pc,
  output logic            if_valid
);
  typedef enum logic [1:0] {BOOT, FETCH, FETCH_IMM} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, pend_pc, pend_pc_n, pc_inc, pc_n_out, next_n;
  logic [15:0] pend_instr, pend_instr_n, instr_n, imm_n;
  logic valid_n;
  assign pc_inc = pc + PC_W'(1);
  assign imem_addr = (state == BOOT) ? PC_W'(RESET_ADDR) : pc;
  // next-state, PC and IF/ID selection; redirect beats stall, stall beats normal fetch
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_instr_n = pend_instr;
    pend_pc_n = pend_pc;
    instr_n = if_instr;
    imm_n = if_imm;
    pc_n_out = if_pc;
    next_n = if_next_pc;
    valid_n = if_valid;
    if (state == BOOT || redirect) begin
      state_n = FETCH;
      pc_n = (state == BOOT) ? PC_W'(imem_data) : redirect_pc;
      pend_instr_n = (state == BOOT) ? pend_instr : '0;
      pend_pc_n = (state == BOOT) ? pend_pc : '0;
      instr_n = '0;
      imm_n = '0;
      pc_n_out = '0;
      next_n = '0;
      valid_n = 1'b0;
    end else if (!stall) begin
      pc_n = pc_inc;
      if (state == FETCH_IMM) begin
        state_n = FETCH;
        instr_n = pend_instr;
        imm_n = imem_data;
        pc_n_out = pend_pc;
        next_n = pc_inc;
        valid_n = 1'b1;
      end else if (imem_data[IMM_BIT]) begin
        state_n = FETCH_IMM;
        pend_instr_n = imem_data;
        pend_pc_n = pc;
        instr_n = '0;
        imm_n = '0;
        pc_n_out = '0;
        next_n = '0;
        valid_n = 1'b0;
      end else begin
        instr_n = imem_data;
        imm_n = '0;
        pc_n_out = pc;
        next_n = pc_inc;
        valid_n = 1'b1;
      end
    end
  end
  // state, PC, pending first word and IF/ID registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BOOT;
      pc <= '0;
      pend_instr <= '0;
      pend_pc <= '0;
      if_instr <= '0;
      if_imm <= '0;
      if_pc <= '0;
      if_next_pc <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend_instr <= pend_instr_n;
      pend_pc <= pend_pc_n;
      if_instr <= instr_n;
      if_imm <= imm_n;
      if_pc <= pc_n_out;
      if_next_pc <= next_n;
      if_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of boot, one/two-word fetch, stall, redirect, wrap and reset
module tb_fetch_stage;
  logic clk = 0, rst = 0, stall = 0, redirect = 0;
  logic [15:0] redirect_pc = 0, imem_addr, imem_data, if_instr, if_imm, if_pc, if_next_pc;
  logic if_valid;
  logic [15:0] mem [0:65535];
  int n_checks = 0, n_fail = 0;
  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;
  fetch_stage dut (.clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .if_instr(if_instr),
    .if_imm(if_imm), .if_pc(if_pc), .if_next_pc(if_next_pc), .if_valid(if_valid));
  task step;
    @(posedge clk);
    #1;
  endtask
  task do_reset(input logic [15:0] boot);
    mem[0] = boot;
    rst = 0; stall = 0; redirect = 0;
    step(); step();
    rst = 1;
    step();
  endtask
  task test_boot;
    mem[0] = 16'h0020; mem[16'h20] = 16'h1111;
    rst = 0; step(); step();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    n_checks++; if ({if_instr, if_imm, if_pc, if_next_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_outs got %h exp 0", {if_instr, if_imm, if_pc, if_next_pc}); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
    rst = 1; step();
    n_checks++; if (imem_addr !== 16'h0020) begin n_fail++; $display("FAIL boot_pc got %h exp 0020", imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL boot_bubble got %b exp 0", if_valid); end
    step();
    n_checks++; if (if_instr !== 16'h1111 || if_pc !== 16'h0020 || if_next_pc !== 16'h0021 || if_valid !== 1'b1 || if_imm !== 16'h0)
      begin n_fail++; $display("FAIL boot_first got %h/%h/%h/%h/%b exp 1111/0000/0020/0021/1", if_instr, if_imm, if_pc, if_next_pc, if_valid); end
  endtask
  task test_two_word;
    mem[16'h20] = 16'h8A53; mem[16'h21] = 16'h1234; mem[16'h22] = 16'h0005;
    do_reset(16'h0020);
    step();
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0021) begin n_fail++; $display("FAIL two_bubble got %b/%h exp 0/0021", if_valid, imem_addr); end
    step();
    n_checks++; if (if_instr !== 16'h8A53 || if_imm !== 16'h1234 || if_pc !== 16'h0020 || if_next_pc !== 16'h0022 || if_valid !== 1'b1)
      begin n_fail++; $display("FAIL two_word got %h/%h/%h/%h/%b exp 8a53/1234/0020/0022/1", if_instr, if_imm, if_pc, if_next_pc, if_valid); end
    n_checks++; if (imem_addr !== 16'h0022) begin n_fail++; $display("FAIL two_pc got %h exp 0022", imem_addr); end
    step();
    n_checks++; if (if_instr !== 16'h0005 || if_imm !== 16'h0 || if_pc !== 16'h0022 || if_valid !== 1'b1)
      begin n_fail++; $display("FAIL two_after got %h/%h/%h/%b exp 0005/0000/0022/1", if_instr, if_imm, if_pc, if_valid); end
  endtask
  task test_stall;
    mem[16'h30] = 16'h0101; mem[16'h31] = 16'h0202; mem[16'h32] = 16'h0303;
    do_reset(16'h0030);
    step();
    n_checks++; if (if_instr !== 16'h0101 || if_pc !== 16'h0030 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pre got %h/%h/%b exp 0101/0030/1", if_instr, if_pc, if_valid); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (if_instr !== 16'h0101 || if_pc !== 16'h0030 || if_next_pc !== 16'h0031 || if_valid !== 1'b1 || imem_addr !== 16'h0031)
        begin n_fail++; $display("FAIL stall_hold%0d got %h/%h/%h/%b/%h exp 0101/0030/0031/1/0031", i, if_instr, if_pc, if_next_pc, if_valid, imem_addr); end
    end
    stall = 0; step();
    n_checks++; if (if_instr !== 16'h0202 || if_pc !== 16'h0031) begin n_fail++; $display("FAIL stall_resume got %h/%h exp 0202/0031", if_instr, if_pc); end
    step();
    n_checks++; if (if_instr !== 16'h0303 || if_pc !== 16'h0032) begin n_fail++; $display("FAIL stall_next got %h/%h exp 0303/0032", if_instr, if_pc); end
  endtask
  task test_redirect_stall;
    mem[16'h100] = 16'h0777;
    stall = 1; redirect = 1; redirect_pc = 16'h0100;
    step();
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 16'h0 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL redir_stall got %b/%h/%h exp 0/0000/0100", if_valid, if_pc, imem_addr); end
    stall = 0; redirect = 0; step();
    n_checks++; if (if_pc !== 16'h0100 || if_instr !== 16'h0777 || if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target got %h/%h/%b exp 0100/0777/1", if_pc, if_instr, if_valid); end
  endtask
  task test_redirect_imm;
    mem[16'h20] = 16'h8A53; mem[16'h21] = 16'h1234; mem[16'h50] = 16'h0ABC;
    do_reset(16'h0020);
    step();
    redirect = 1; redirect_pc = 16'h0050; step();
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0050) begin n_fail++; $display("FAIL redir_imm_bubble got %b/%h exp 0/0050", if_valid, imem_addr); end
    redirect = 0; step();
    n_checks++; if (if_pc !== 16'h0050 || if_instr !== 16'h0ABC || if_imm !== 16'h0 || if_valid !== 1'b1)
      begin n_fail++; $display("FAIL redir_imm_target got %h/%h/%h/%b exp 0050/0abc/0000/1", if_pc, if_instr, if_imm, if_valid); end
  endtask
  task test_wrap;
    mem[16'hFFFF] = 16'h0001;
    do_reset(16'hFFFF);
    step();
    n_checks++; if (if_instr !== 16'h0001 || if_pc !== 16'hFFFF || if_next_pc !== 16'h0000 || imem_addr !== 16'h0000)
      begin n_fail++; $display("FAIL wrap got %h/%h/%h/%h exp 0001/ffff/0000/0000", if_instr, if_pc, if_next_pc, imem_addr); end
  endtask
  task test_reset_mid_imm;
    mem[16'h60] = 16'h0123; mem[16'h61] = 16'h8A53; mem[16'h62] = 16'h1234;
    do_reset(16'h0060);
    step(); step();
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0062) begin n_fail++; $display("FAIL mid_imm_setup got %b/%h exp 0/0062", if_valid, imem_addr); end
    rst = 0; step();
    n_checks++; if (imem_addr !== 16'h0000 || {if_instr, if_imm, if_pc, if_next_pc} !== 64'h0 || if_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_imm_reset got %h/%h/%b exp 0000/0/0", imem_addr, {if_instr, if_imm, if_pc, if_next_pc}, if_valid); end
    rst = 1; step(); step();
    n_checks++; if (if_instr !== 16'h0123 || if_imm !== 16'h0 || if_pc !== 16'h0060 || if_valid !== 1'b1)
      begin n_fail++; $display("FAIL mid_imm_reboot got %h/%h/%h/%b exp 0123/0000/0060/1", if_instr, if_imm, if_pc, if_valid); end
  endtask
  initial begin
    test_boot();
    test_two_word();
    test_stall();
    test_redirect_stall();
    test_redirect_imm();
    test_wrap();
    test_reset_mid_imm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
